// File: rtl/tdm_deserializer.sv
// TDM serial-to-parallel front end: recovers NUM_CHANNELS words per sync-delimited
// frame, tags each with its channel and queues them in a show-ahead FIFO.
module tdm_deserializer #(
  parameter int DATA_WIDTH   = 24,
  parameter int NUM_CHANNELS = 2,
  parameter int FIFO_DEPTH   = 4,
  parameter int MSB_FIRST    = 1,
  localparam int CH_W        = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
  localparam int LVL_W       = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_en,
  input  logic                  i_din,
  input  logic                  i_din_valid,
  input  logic                  i_frame_sync,
  output logic [DATA_WIDTH-1:0] ov_dout,
  output logic [CH_W-1:0]       ov_chan,
  output logic                  o_dout_valid,
  input  logic                  i_dout_ready,
  output logic                  o_frame_err,
  output logic                  o_overflow,
  output logic [LVL_W-1:0]      ov_level
);

  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int ENT_W = CH_W + DATA_WIDTH;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);
  localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CHANNELS - 1);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    HUNT      = 2'd0,
    RUN       = 2'd1,
    SYNC_WAIT = 2'd2
  } state_t;

  state_t              state;
  logic [BIT_W-1:0]    bit_cnt;
  logic [CH_W-1:0]     ch_cnt;
  logic [DATA_WIDTH-1:0] word;

  logic                  accepted;
  logic                  start_frame;
  logic                  take_bit;
  logic                  mid_err;
  logic                  wait_err;
  logic [BIT_W-1:0]      eff_bit;
  logic [CH_W-1:0]       eff_ch;
  logic [DATA_WIDTH-1:0] base_word;
  logic [DATA_WIDTH-1:0] next_word;
  logic                  word_done;
  logic [ENT_W-1:0]      push_data;

  // A sync bit always restarts the frame at bit 0 of channel 0, discarding any
  // partial word; the counters are viewed as already zeroed for that bit.
  always_comb begin
    accepted    = i_en && i_din_valid;
    start_frame = accepted && i_frame_sync;
    mid_err     = start_frame && (state == RUN) &&
                  ((bit_cnt != '0) || (ch_cnt != '0));
    wait_err    = accepted && !i_frame_sync && (state == SYNC_WAIT);
    take_bit    = start_frame || (accepted && (state == RUN));
    eff_bit     = start_frame ? '0 : bit_cnt;
    eff_ch      = start_frame ? '0 : ch_cnt;
    base_word   = start_frame ? '0 : word;
    if (MSB_FIRST != 0) begin
      next_word = {base_word[DATA_WIDTH-2:0], i_din};
    end else begin
      next_word = {i_din, base_word[DATA_WIDTH-1:1]};
    end
    word_done   = take_bit && (eff_bit == LAST_BIT);
    push_data   = {eff_ch, next_word};
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= HUNT;
      bit_cnt     <= '0;
      ch_cnt      <= '0;
      word        <= '0;
      o_frame_err <= 1'b0;
    end else begin
      o_frame_err <= mid_err || wait_err;
      if (wait_err) begin
        state <= HUNT;
      end else if (take_bit) begin
        word <= next_word;
        if (word_done) begin
          bit_cnt <= '0;
          if (eff_ch == LAST_CH) begin
            ch_cnt <= '0;
            state  <= SYNC_WAIT;
          end else begin
            ch_cnt <= eff_ch + CH_W'(1);
            state  <= RUN;
          end
        end else begin
          bit_cnt <= eff_bit + BIT_W'(1);
          ch_cnt  <= eff_ch;
          state   <= RUN;
        end
      end
    end
  end

  logic [ENT_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [LVL_W-1:0] count;
  logic             pop;
  logic             full;
  logic             do_push;
  logic             drop;

  // A push into a full FIFO survives only when the head leaves on the same edge.
  always_comb begin
    pop     = o_dout_valid && i_dout_ready;
    full    = (count == FULL_LVL);
    do_push = word_done && (!full || pop);
    drop    = word_done && full && !pop;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      o_overflow <= 1'b0;
    end else begin
      o_overflow <= drop;
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + LVL_W'(do_push) - LVL_W'(pop);
    end
  end

  assign o_dout_valid      = (count != '0);
  assign {ov_chan, ov_dout} = mem[rd_ptr];
  assign ov_level          = count;

endmodule

// File: doc/tdm_deserializer.md
# tdm_deserializer

Multi-channel, time-division-multiplexed serial-to-parallel front end for the serial FIR datapath. It is the parametrised successor to the single-channel deserializer. It recovers NUM_CHANNELS words of DATA_WIDTH bits per frame from a 1-bit stream delimited by a frame-sync pulse, and tags each word with its channel index. Words are buffered in a small show-ahead FIFO with a valid/ready output handshake, so the downstream filter can stall. Framing errors and FIFO overflows are detected and reported.

## Interface
- DATA_WIDTH, 24, bits per channel word
- NUM_CHANNELS, 2, words per frame (>=1)
- FIFO_DEPTH, 4, output FIFO entries (power of two, >=2)
- MSB_FIRST, 1, 1: first serial bit is word MSB; 0: first bit is LSB
- CH_W, derived = max(1, clog2(NUM_CHANNELS)), channel tag width
- i_clk  in  1  single clock, all logic rising-edge
- i_rst_n  in  1  reset, asynchronous, active-low
- i_en  in  1  block enable; when low, input bits are ignored and framing state holds
- i_din  in  1  serial data bit
- i_din_valid  in  1  i_din carries a bit this cycle
- i_frame_sync  in  1  qualified by i_din_valid; marks the first bit of a frame
- ov_dout  out  DATA_WIDTH  FIFO head word
- ov_chan  out  CH_W  channel index of head word
- o_dout_valid  out  1  FIFO non-empty
- i_dout_ready  in  1  consumer accepts head word when o_dout_valid && i_dout_ready
- o_frame_err  out  1  one-cycle pulse on framing error
- o_overflow  out  1  one-cycle pulse when a completed word is dropped because the FIFO is full
- ov_level  out  clog2(FIFO_DEPTH)+1  FIFO occupancy

## Operation
- An accepted bit is one where i_en && i_din_valid. All framing logic advances only on accepted bits.
- Counters: bit_cnt counts 0..DATA_WIDTH-1; ch_cnt counts 0..NUM_CHANNELS-1.
- FSM states:
  - HUNT: discard accepted bits until an accepted bit with i_frame_sync=1. That bit becomes bit 0 of channel 0; go to RUN.
  - RUN: shift each accepted bit into the word register.
    - MSB_FIRST=1: shift left, new bit at LSB.
    - MSB_FIRST=0: shift right, new bit at MSB.
    - On bit_cnt=DATA_WIDTH-1, push {ch_cnt, assembled word} into the FIFO, clear bit_cnt and increment ch_cnt.
    - After the last bit of channel NUM_CHANNELS-1, go to SYNC_WAIT.
  - SYNC_WAIT: the next accepted bit must carry i_frame_sync=1.
    - If it does: that bit is bit 0 of channel 0; go to RUN.
    - If it does not: pulse o_frame_err, discard the bit, go to HUNT.
- Sync in RUN at any position other than bit 0 of channel 0:
  - pulse o_frame_err and discard the partial word;
  - words already pushed in this frame remain in the FIFO;
  - the sync bit is taken as bit 0 of channel 0 of a new frame; stay in RUN.
- Sync on the very bit that completes a word still counts as mid-frame. That word is discarded, not pushed.
- FIFO behaviour:
  - Show-ahead: ov_dout and ov_chan reflect the head entry whenever o_dout_valid=1.
  - A pop occurs on o_dout_valid && i_dout_ready.
  - Push while full with no simultaneous pop: the word is dropped, o_overflow pulses, and framing continues normally.
  - Push and pop in the same cycle while full: both are performed and there is no overflow.
  - Push and pop in the same cycle while empty: only the push takes effect (nothing to pop).
- i_en low: the FIFO output side still operates (pops allowed). Framing state and partial word hold.
- ov_chan, ov_dout and ov_level are 0 when the FIFO is empty after reset. Stale data is permitted after pops, but o_dout_valid is authoritative.

## Timing
- Reset (i_rst_n low, asynchronous):
  - FSM goes to HUNT; bit_cnt, ch_cnt and word register clear to 0.
  - FIFO empties.
  - o_dout_valid=0, ov_dout=0, ov_chan=0, ov_level=0, o_frame_err=0, o_overflow=0.
- Reset mid-frame discards the partial word and all FIFO contents. After release, the block waits in HUNT.
- Latency: the last bit of a word is accepted at edge N. The FIFO write occurs at edge N. o_dout_valid=1 and data are visible after edge N (first cycle after).
- ov_level updates at the same edge as the push or pop.
- o_frame_err and o_overflow are registered. Each is high for exactly the one cycle following the offending edge.
- Throughput: one word per DATA_WIDTH accepted bits. Back-to-back frames with no gap are supported, with the sync bit immediately after the final bit.

## Test plan
- Reset, then NUM_CHANNELS=2, MSB_FIRST=1: one frame with sync on the first bit, bits of 0xA5A5A5 then 0x3C3C3C, i_dout_ready=1 -> two words 0xA5A5A5/chan 0 and 0x3C3C3C/chan 1; o_dout_valid asserts the cycle after each last bit; no error pulses.
- MSB_FIRST=0 variant: stream 0x000001 LSB-first (1 then 23 zeros) -> ov_dout=0x000001.
- Back-to-back frames with i_din_valid toggling 50% and i_en low for 10 cycles mid-word -> same words as the contiguous stream; counters hold while i_en=0.
- Sync asserted at bit 10 of channel 1 -> one o_frame_err pulse; the partial channel-1 word is never output; the next frame from that bit decodes correctly. Next, a non-sync bit in SYNC_WAIT -> o_frame_err pulse; bits ignored until the next sync.
- i_dout_ready=0 across 3 frames (6 words, FIFO_DEPTH=4) -> ov_level reaches 4, o_overflow pulses twice, and the first 4 words are retained in order. Then a push coincident with a pop while full -> no overflow, ov_level stays 4.
- Assert i_rst_n low asynchronously mid-word with the FIFO holding 2 words -> all outputs 0 immediately; after release, words appear only after a new sync.
